// File: rtl/axil_write_master.sv
// AXI4-Lite single-beat write initiator driven from a valid/ready command port.
// One write in flight at a time; completion is pulsed on done and error responses are counted.
module axil_write_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [STRB_WIDTH-1:0] cmd_strb,

    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  busy,
    output logic [ERR_WIDTH-1:0]  err_count,

    output logic [ADDR_WIDTH-1:0] axil_awaddr,
    output logic [2:0]            axil_awprot,
    output logic                  axil_awvalid,
    input  logic                  axil_awready,
    output logic [DATA_WIDTH-1:0] axil_wdata,
    output logic [STRB_WIDTH-1:0] axil_wstrb,
    output logic                  axil_wvalid,
    input  logic                  axil_wready,
    input  logic [1:0]            axil_bresp,
    input  logic                  axil_bvalid,
    output logic                  axil_bready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    done_q,      done_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic                    busy_q,      busy_d;
    logic [ERR_WIDTH-1:0]    err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    bready_q,    bready_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        busy_d      = busy_q;
        err_count_d = err_count_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    awaddr_d    = cmd_addr;
                    wdata_d     = cmd_data;
                    wstrb_d     = cmd_strb;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // AW and W retire independently; B is awaited once both are gone
                awvalid_d = awvalid_q && !axil_awready;
                wvalid_d  = wvalid_q && !axil_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (axil_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    done_d      = 1'b1;
                    done_resp_d = axil_bresp;
                    if ((axil_bresp != 2'b00) && (err_count_q != '1)) begin
                        err_count_d = err_count_q + ERR_WIDTH'(1);
                    end
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            busy_q      <= 1'b0;
            err_count_q <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            busy_q      <= busy_d;
            err_count_q <= err_count_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign done         = done_q;
    assign done_resp    = done_resp_q;
    assign busy         = busy_q;
    assign err_count    = err_count_q;
    assign axil_awaddr  = awaddr_q;
    assign axil_awprot  = 3'b000;
    assign axil_awvalid = awvalid_q;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_wvalid  = wvalid_q;
    assign axil_bready  = bready_q;

endmodule

// File: tb/tb_axil_write_master.sv
// Bench for axil_write_master: latency-configurable AXI-Lite slave, handshake logger and a
// transaction-level model of latency, response and saturating error count.
module tb_axil_write_master;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 24;
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned EW      = 4;
    localparam int unsigned ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_strb;
    logic          done;
    logic [1:0]    done_resp;
    logic          busy;
    logic [EW-1:0] err_count;
    logic [AW-1:0] axil_awaddr;
    logic [2:0]    axil_awprot;
    logic          axil_awvalid;
    logic          axil_awready;
    logic [DW-1:0] axil_wdata;
    logic [SW-1:0] axil_wstrb;
    logic          axil_wvalid;
    logic          axil_wready;
    logic [1:0]    axil_bresp;
    logic          axil_bvalid;
    logic          axil_bready;

    axil_write_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW),
        .ERR_WIDTH (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_strb    (cmd_strb),
        .done        (done),
        .done_resp   (done_resp),
        .busy        (busy),
        .err_count   (err_count),
        .axil_awaddr (axil_awaddr),
        .axil_awprot (axil_awprot),
        .axil_awvalid(axil_awvalid),
        .axil_awready(axil_awready),
        .axil_wdata  (axil_wdata),
        .axil_wstrb  (axil_wstrb),
        .axil_wvalid (axil_wvalid),
        .axil_wready (axil_wready),
        .axil_bresp  (axil_bresp),
        .axil_bvalid (axil_bvalid),
        .axil_bready (axil_bready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned err_exp = 0;

    // Slave configuration, set by the main sequence before each command
    int unsigned aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        spur = 1'b0;

    // Slave/monitor state
    int unsigned   aw_wait = 0, w_wait = 0, b_wait = 0;
    int unsigned   aw_n = 0, w_n = 0, b_n = 0;
    logic          aw_pred = 1'b0, w_pred = 1'b0, b_pred = 1'b0;
    logic [AW-1:0] aw_pred_addr;
    logic [DW-1:0] w_pred_data;
    logic [SW-1:0] w_pred_strb;
    logic          aw_hold = 1'b0, w_hold = 1'b0;
    logic [AW-1:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    logic [SW-1:0] prev_wstrb;
    int unsigned   proto_err = 0;
    logic [AW-1:0] aw_log[$];
    logic [DW-1:0] wd_log[$];
    logic [SW-1:0] ws_log[$];
    int unsigned   done_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave and handshake logger: drives at the falling edge, predicts the handshakes of the next
    // rising edge and commits them one falling edge later.
    initial begin
        axil_awready = 1'b0;
        axil_wready  = 1'b0;
        axil_bvalid  = 1'b0;
        axil_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (aw_pred) begin aw_n++; aw_log.push_back(aw_pred_addr); end
            if (w_pred)  begin w_n++;  wd_log.push_back(w_pred_data); ws_log.push_back(w_pred_strb); end
            if (b_pred)  b_n++;
            aw_pred = 1'b0;
            w_pred  = 1'b0;
            b_pred  = 1'b0;
            if (done) done_log.push_back(cyc);
            if (rst) begin
                aw_n = b_n;
                w_n  = b_n;
                aw_hold = 1'b0;
                w_hold  = 1'b0;
                axil_awready = 1'b0;
                axil_wready  = 1'b0;
                axil_bvalid  = 1'b0;
                axil_bresp   = 2'b00;
                continue;
            end
            if (aw_hold && axil_awvalid && axil_awaddr != prev_awaddr) proto_err++;
            if (w_hold && axil_wvalid && (axil_wdata != prev_wdata || axil_wstrb != prev_wstrb)) proto_err++;
            if (aw_hold && !axil_awvalid) proto_err++;
            if (w_hold && !axil_wvalid) proto_err++;
            if (axil_bready && !(aw_n > b_n && w_n > b_n)) proto_err++;

            if (aw_n > b_n && w_n > b_n) begin
                if (b_wait == 0) begin
                    axil_bvalid = 1'b1;
                    axil_bresp  = bresp_cfg;
                end else begin
                    b_wait--;
                    axil_bvalid = 1'b0;
                end
            end else begin
                b_wait      = b_lat;
                axil_bvalid = spur;
                axil_bresp  = spur ? 2'b10 : 2'b00;
            end

            if (!axil_awvalid) begin aw_wait = aw_lat; axil_awready = 1'b0; end
            else if (aw_wait == 0) axil_awready = 1'b1;
            else begin aw_wait--; axil_awready = 1'b0; end

            if (!axil_wvalid) begin w_wait = w_lat; axil_wready = 1'b0; end
            else if (w_wait == 0) axil_wready = 1'b1;
            else begin w_wait--; axil_wready = 1'b0; end

            aw_pred      = axil_awvalid && axil_awready;
            aw_pred_addr = axil_awaddr;
            w_pred       = axil_wvalid && axil_wready;
            w_pred_data  = axil_wdata;
            w_pred_strb  = axil_wstrb;
            b_pred       = axil_bvalid && axil_bready;
            aw_hold      = axil_awvalid && !axil_awready;
            w_hold       = axil_wvalid && !axil_wready;
            prev_awaddr  = axil_awaddr;
            prev_wdata   = axil_wdata;
            prev_wstrb   = axil_wstrb;
        end
    end

    // Presents a command and returns once the accepting edge has passed
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int unsigned n;
        n = 0;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int unsigned al, input int unsigned wl, input int unsigned bl,
                            input logic [1:0] br);
        int unsigned n;
        int unsigned m;
        int aw0;
        int w0;
        aw_lat    = al;
        w_lat     = wl;
        b_lat     = bl;
        bresp_cfg = br;
        aw0 = aw_log.size();
        w0  = wd_log.size();
        issue(a, d, s);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        m = (al > wl) ? al : wl;
        check("done_latency", n, 2 + m + bl);
        check("done_resp", 32'(done_resp), 32'(br));
        if (br != 2'b00 && err_exp < ERR_MAX) err_exp++;
        check("err_count", 32'(err_count), err_exp);
        check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("aw_handshakes", 32'(aw_log.size() - aw0), 32'd1);
        check("w_handshakes", 32'(wd_log.size() - w0), 32'd1);
        check("awaddr", 32'(aw_log[$]), 32'(a));
        check("wdata", wd_log[$], d);
        check("wstrb", 32'(ws_log[$]), 32'(s));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] bdata[8];
        int d0;
        int a0;
        int unsigned n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_strb  = '0;
        tick(); tick(); tick();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_resp", 32'(done_resp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_awvalid", 32'(axil_awvalid), 32'd0);
        check("rst_wvalid", 32'(axil_wvalid), 32'd0);
        check("rst_bready", 32'(axil_bready), 32'd0);
        check("rst_awaddr", 32'(axil_awaddr), 32'd0);
        check("rst_wdata", axil_wdata, 32'd0);
        check("rst_wstrb", 32'(axil_wstrb), 32'd0);
        check("awprot", 32'(axil_awprot), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait slave
        do_write(24'h000100, 32'h00000ABC, 4'hF, 0, 0, 0, 2'b00);
        // AW accepted after 4 cycles of awvalid, W immediately
        do_write(24'h000200, 32'hDEADBEEF, 4'h5, 3, 0, 0, 2'b00);
        // W delayed instead, with a slow response
        do_write(24'h000204, 32'h12345678, 4'hA, 0, 2, 3, 2'b00);
        // Three SLVERR responses
        for (int i = 0; i < 3; i++) do_write(AW'(24'h300 + 4 * i), $urandom, 4'hF, 0, 0, 0, 2'b10);

        // Back-to-back commands with cmd_valid held
        aw_lat = 0; w_lat = 0; b_lat = 0; bresp_cfg = 2'b00;
        d0 = done_log.size();
        a0 = aw_log.size();
        for (int i = 0; i < 8; i++) begin
            bdata[i] = $urandom;
            issue(AW'(4 * i), bdata[i], 4'hF);
            if (i < 7) cmd_valid = 1'b1;
        end
        n = 0;
        while ((done_log.size() - d0) < 8 && n < 100) begin tick(); n++; end
        tick(); tick();
        check("burst_done_count", 32'(done_log.size() - d0), 32'd8);
        check("burst_aw_count", 32'(aw_log.size() - a0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("burst_awaddr", 32'(aw_log[a0 + i]), 32'(4 * i));
            check("burst_wdata", wd_log[a0 + i], bdata[i]);
            if (i > 0) check("burst_done_spacing", done_log[d0 + i] - done_log[d0 + i - 1], 32'd3);
        end

        // Spurious bvalid while idle
        spur = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("spur_bready", 32'(axil_bready), 32'd0);
            check("spur_done", 32'(done), 32'd0);
            check("spur_busy", 32'(busy), 32'd0);
        end
        spur = 1'b0;
        tick();
        check("spur_err_count", 32'(err_count), err_exp);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            do_write(AW'($urandom) & ~AW'(3), $urandom, SW'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        // Drive the error counter into saturation and past it
        while (err_exp < ERR_MAX) do_write(24'h000400, $urandom, 4'hF, 0, 0, 0, 2'b11);
        do_write(24'h000404, $urandom, 4'hF, 1, 1, 0, 2'b10);
        do_write(24'h000408, $urandom, 4'hF, 0, 0, 0, 2'b10);

        // Reset while AW is still outstanding
        aw_lat = 6; w_lat = 0; b_lat = 0; bresp_cfg = 2'b00;
        d0 = done_log.size();
        issue(24'h000500, 32'hCAFEF00D, 4'hF);
        tick();
        check("pre_rst_awvalid", 32'(axil_awvalid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_exp = 0;
        check("midrst_awvalid", 32'(axil_awvalid), 32'd0);
        check("midrst_wvalid", 32'(axil_wvalid), 32'd0);
        check("midrst_bready", 32'(axil_bready), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_done", 32'(done_log.size() - d0), 32'd0);
        do_write(24'h000600, 32'h0BADC0DE, 4'h3, 1, 0, 1, 2'b00);
        do_write(24'h000604, 32'h600DF00D, 4'hC, 0, 0, 0, 2'b01);

        check("protocol_violations", proto_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
